// File: rtl/zebra_pkg.sv
// Shared types and default thresholds for the zebra-crossing video pipeline.
package zebra_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMING    = 2'd1,
        S_STOP      = 2'd2,
        S_RELEASING = 2'd3
    } stop_state_e;

    localparam int unsigned DEF_ON_FRAMES       = 3;
    localparam int unsigned DEF_OFF_FRAMES      = 5;
    localparam int unsigned DEF_MIN_HOLD_FRAMES = 10;
    localparam int unsigned DEF_MIN_BLOBS       = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 1_000_000;

    // Width of the frame debounce / hold counters.
    localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/frame_watchdog.sv
// Watchdog that flags when no frame verdict has arrived for TIMEOUT_CYCLES cycles.
// cnt holds the number of cycles elapsed since the last kick (the kick cycle
// itself counts as one), so expired rises exactly TIMEOUT_CYCLES cycles after
// the last kick.
module frame_watchdog
    import zebra_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Saturating elapsed-cycle counter with a registered expiry flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (kick) begin
            cnt     <= CW'(1);
            expired <= (TIMEOUT_CYCLES == 1);
        end else begin
            if (cnt != LIMIT) begin
                cnt <= cnt + 1'b1;
            end
            expired <= (cnt >= LIMIT - 1'b1);
        end
    end

endmodule

// File: rtl/crossing_stop_filter.sv
// Debounced, hysteretic zebra-crossing stop request built from per-frame verdicts.
// Input protocol is valid-only (no ready): every cycle with detection_valid high
// carries exactly one frame verdict (crossing_detected, blob_count), and it is
// always consumed in that cycle unless clear is high in the same cycle, in which
// case the frame is dropped.
module crossing_stop_filter
    import zebra_pkg::*;
#(
    parameter int unsigned ON_FRAMES       = DEF_ON_FRAMES,
    parameter int unsigned OFF_FRAMES      = DEF_OFF_FRAMES,
    parameter int unsigned MIN_HOLD_FRAMES = DEF_MIN_HOLD_FRAMES,
    parameter int unsigned MIN_BLOBS       = DEF_MIN_BLOBS,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        detection_valid,
    input  logic        crossing_detected,
    input  logic [7:0]  blob_count,
    output logic        stop,
    output logic        stop_rise,
    output logic        stop_fall,
    output logic [7:0]  blob_latched,
    output logic [15:0] frame_count,
    output logic        timeout,
    output logic [1:0]  state
);

    localparam int unsigned CW = FRAME_CNT_W;
    localparam logic [CW-1:0] ON_LIM   = CW'(ON_FRAMES);
    localparam logic [CW-1:0] OFF_LIM  = CW'(OFF_FRAMES);
    localparam logic [CW-1:0] HOLD_LIM = CW'(MIN_HOLD_FRAMES);
    localparam logic [7:0]    BLOB_LIM = 8'(MIN_BLOBS);

    stop_state_e   state_q, state_d;
    logic [CW-1:0] on_q, on_d;
    logic [CW-1:0] off_q, off_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          stop_prev;
    logic          pos_frame;
    logic          neg_frame;

    assign pos_frame = detection_valid && crossing_detected && (blob_count >= BLOB_LIM);
    assign neg_frame = detection_valid && !pos_frame;

    frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .kick   (detection_valid),
        .clear  (clear),
        .expired(timeout)
    );

    // Next-state and counter logic; only valid frames move the FSM.
    always_comb begin
        state_d = state_q;
        on_d    = on_q;
        off_d   = off_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (pos_frame) begin
                    on_d    = CW'(1);
                    off_d   = '0;
                    hold_d  = '0;
                    state_d = (ON_LIM == CW'(1)) ? S_STOP : S_ARMING;
                end
            end
            S_ARMING: begin
                if (pos_frame) begin
                    on_d = on_q + 1'b1;
                    if (on_q + 1'b1 == ON_LIM) begin
                        state_d = S_STOP;
                        hold_d  = '0;
                        off_d   = '0;
                    end
                end else if (neg_frame) begin
                    on_d    = '0;
                    state_d = S_IDLE;
                end
            end
            S_STOP: begin
                if (detection_valid && (hold_q < HOLD_LIM)) begin
                    hold_d = hold_q + 1'b1;
                end
                // Hold check uses the count before this frame's increment.
                if (neg_frame && (hold_q >= HOLD_LIM)) begin
                    off_d   = CW'(1);
                    state_d = (OFF_LIM == CW'(1)) ? S_IDLE : S_RELEASING;
                end
            end
            S_RELEASING: begin
                if (pos_frame) begin
                    off_d   = '0;
                    state_d = S_STOP;
                end else if (neg_frame) begin
                    off_d = off_q + 1'b1;
                    if (off_q + 1'b1 == OFF_LIM) begin
                        off_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, counters and per-frame bookkeeping; clear wins over a coincident frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            on_q         <= '0;
            off_q        <= '0;
            hold_q       <= '0;
            blob_latched <= '0;
            frame_count  <= '0;
        end else if (clear) begin
            state_q      <= S_IDLE;
            on_q         <= '0;
            off_q        <= '0;
            hold_q       <= '0;
            blob_latched <= '0;
            frame_count  <= '0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            off_q   <= off_d;
            hold_q  <= hold_d;
            if (detection_valid) begin
                blob_latched <= blob_count;
                frame_count  <= frame_count + 1'b1;
            end
        end
    end

    // Previous stop value; deliberately not cleared by clear so a clear that
    // drops stop still produces a stop_fall pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_prev <= 1'b0;
        end else begin
            stop_prev <= stop;
        end
    end

    assign stop      = (state_q == S_STOP) || (state_q == S_RELEASING) || timeout;
    assign stop_rise = stop && !stop_prev;
    assign stop_fall = !stop && stop_prev;
    assign state     = state_q;

endmodule
